// File: rtl/prog_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: widths, state encoding
// and the last-address constant that marks end of program.
package prog_fetch_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NIB_W  = 4;

  localparam logic [DEF_ADDR_W-1:0] ADDR_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    HI    = 3'd3,
    LO    = 3'd4,
    INC   = 3'd5
  } state_e;

endpackage

// File: rtl/prog_fetch_if.sv
// Handshake bundle between the fetch sequencer (master) and its program counter,
// ROM and bus consumer (slave side). The tri-stated nibble bus stays a plain net.
interface prog_fetch_if
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              FETCH;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_EN;
  logic [DATA_W-1:0] MEM_DATA;
  logic              BUS_VALID;
  logic              BUS_HI;
  logic              BUS_ACK;
  logic              PC_INC;
  logic              BUSY;
  logic              END_OF_PROG;

  modport master (
    input  FETCH, ADDR_IN, MEM_DATA, BUS_ACK,
    output MEM_ADDR, MEM_EN, BUS_VALID, BUS_HI, PC_INC, BUSY, END_OF_PROG
  );

  modport slave (
    output FETCH, ADDR_IN, MEM_DATA, BUS_ACK,
    input  MEM_ADDR, MEM_EN, BUS_VALID, BUS_HI, PC_INC, BUSY, END_OF_PROG
  );

endinterface

// File: rtl/prog_fetch.sv
// Instruction fetch sequencer: reads one ROM word per request and hands it to the
// shared 4-bit bus as two acknowledged nibbles, high nibble first.
module prog_fetch
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NIB_W  = DEF_NIB_W
) (
  input  logic             Clk,
  input  logic             Rst,
  prog_fetch_if.master     bus,
  output wire [NIB_W-1:0]  BUS_OUT
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              eop_q, eop_d;
  logic [NIB_W-1:0]  nib;
  logic              drive;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      eop_q   <= eop_d;
    end
  end

  // addr_q only loads in IDLE, so a counter change mid-fetch cannot alter the word in flight
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    eop_d   = eop_q;
    unique case (state_q)
      IDLE: begin
        if (bus.FETCH && !eop_q) begin
          addr_d  = bus.ADDR_IN;
          state_d = READ;
        end
      end
      READ:  state_d = LATCH;
      LATCH: begin
        word_d  = bus.MEM_DATA;
        state_d = HI;
      end
      HI: begin
        if (bus.BUS_ACK) state_d = LO;
      end
      LO: begin
        if (bus.BUS_ACK) state_d = INC;
      end
      INC: begin
        if (&addr_q) eop_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is a decode of registered state; BUS_ACK never reaches BUS_OUT combinationally
  assign bus.MEM_ADDR    = addr_q;
  assign bus.MEM_EN      = (state_q == READ);
  assign bus.BUS_VALID   = drive;
  assign bus.BUS_HI      = (state_q == HI);
  assign bus.PC_INC      = (state_q == INC);
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.END_OF_PROG = eop_q;

  assign drive   = (state_q == HI) || (state_q == LO);
  assign nib     = (state_q == HI) ? word_q[DATA_W-1:NIB_W] : word_q[NIB_W-1:0];
  assign BUS_OUT = drive ? nib : {NIB_W{1'bz}};

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: synchronous ROM model, directed plus randomized
// fetches, expectations derived from word contents and nibble/ACK timing rules.
module tb_prog_fetch;
  import prog_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  wire  [3:0] bus_out;
  logic [7:0] rom [256];

  int tests = 0;
  int failed = 0;
  int inc_seen = 0;
  int inc_exp = 0;
  bit eop_exp = 1'b0;

  prog_fetch_if bus_if ();

  prog_fetch dut (
    .Clk    (clk),
    .Rst    (rst),
    .bus    (bus_if.master),
    .BUS_OUT(bus_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.MEM_EN) bus_if.MEM_DATA <= rom[bus_if.MEM_ADDR];
  end

  always @(posedge clk) begin
    if (bus_if.PC_INC === 1'b1) inc_seen <= inc_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete fetch; dh/dl are the ACK wait cycles for the high/low nibble
  task automatic do_fetch(input logic [7:0] a, input int dh_in, input int dl,
                          input bit early, input bit disturb);
    logic [7:0] w;
    int dh;
    w  = rom[a];
    dh = early ? 0 : dh_in;
    bus_if.ADDR_IN = a;
    bus_if.FETCH   = 1'b1;
    bus_if.BUS_ACK = 1'b0;
    tick();
    bus_if.FETCH = 1'b0;
    check("read_en", {bus_if.MEM_EN, bus_if.BUSY}, 2'b11);
    check("read_addr", bus_if.MEM_ADDR, a);
    if (early) bus_if.BUS_ACK = 1'b1;
    tick();
    check("latch_quiet", {bus_if.MEM_EN, bus_if.BUS_VALID, bus_if.BUSY}, 3'b001);
    tick();
    for (int k = 0; k <= dh; k++) begin
      check("hi_nibble", {bus_if.BUS_VALID, bus_if.BUS_HI, bus_out}, {2'b11, w[7:4]});
      if (disturb && k == 0) begin
        bus_if.FETCH   = 1'b1;
        bus_if.ADDR_IN = a + 8'd1;
      end else begin
        bus_if.FETCH = 1'b0;
      end
      bus_if.BUS_ACK = (k == dh);
      tick();
    end
    bus_if.FETCH = 1'b0;
    for (int k = 0; k <= dl; k++) begin
      check("lo_nibble", {bus_if.BUS_VALID, bus_if.BUS_HI, bus_out}, {2'b10, w[3:0]});
      bus_if.BUS_ACK = (k == dl);
      tick();
    end
    bus_if.BUS_ACK = 1'b0;
    check("inc_pulse", {bus_if.PC_INC, bus_if.BUSY, bus_if.BUS_VALID}, 3'b110);
    if (a == ADDR_ALL_ONES) eop_exp = 1'b1;
    inc_exp++;
    tick();
    check("back_idle", {bus_if.BUSY, bus_if.PC_INC, bus_if.MEM_EN, bus_if.BUS_VALID}, 4'b0000);
    check("eop_flag", bus_if.END_OF_PROG, eop_exp);
    tick();
    check("stay_idle", bus_if.BUSY, 1'b0);
    check("inc_count", inc_seen, inc_exp);
  endtask

  initial begin
    logic [7:0] ra;
    rst            = 1'b1;
    bus_if.FETCH   = 1'b0;
    bus_if.ADDR_IN = '0;
    bus_if.BUS_ACK = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h10] = 8'hA7;
    rom[8'h11] = 8'h5E;
    rom[8'hFF] = 8'h3C;

    tick();
    tick();
    rst = 1'b0;
    check("rst_ctrl", {bus_if.MEM_EN, bus_if.BUS_VALID, bus_if.BUS_HI, bus_if.PC_INC,
                       bus_if.BUSY, bus_if.END_OF_PROG}, 6'b0);
    check("rst_addr", bus_if.MEM_ADDR, 8'h00);

    do_fetch(8'h10, 0, 0, 1'b0, 1'b0);
    do_fetch(8'h42, 3, 3, 1'b0, 1'b0);
    do_fetch(8'h43, 0, 0, 1'b1, 1'b0);
    do_fetch(8'h44, 0, 2, 1'b1, 1'b0);
    do_fetch(8'h10, 1, 0, 1'b0, 1'b1);
    do_fetch(8'h10, 0, 1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 254));
      do_fetch(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom));
    end

    // Reset while the low nibble is on the bus
    bus_if.ADDR_IN = 8'h55;
    bus_if.FETCH   = 1'b1;
    tick();
    bus_if.FETCH = 1'b0;
    tick();
    tick();
    bus_if.BUS_ACK = 1'b1;
    tick();
    bus_if.BUS_ACK = 1'b0;
    check("pre_rst_lo", {bus_if.BUS_VALID, bus_if.BUS_HI, bus_out}, {2'b10, rom[8'h55][3:0]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ctrl", {bus_if.BUSY, bus_if.BUS_VALID, bus_if.PC_INC, bus_if.MEM_EN}, 4'b0);
    check("rst_mid_addr", bus_if.MEM_ADDR, 8'h00);
    tick();
    check("rst_no_inc", inc_seen, inc_exp);
    do_fetch(8'h56, 1, 1, 1'b0, 1'b0);

    // Last address: flag becomes sticky and blocks requests until reset
    do_fetch(ADDR_ALL_ONES, 0, 1, 1'b0, 1'b0);
    bus_if.ADDR_IN = 8'h20;
    bus_if.FETCH   = 1'b1;
    tick();
    check("eop_blocks", {bus_if.BUSY, bus_if.MEM_EN}, 2'b00);
    tick();
    bus_if.FETCH = 1'b0;
    check("eop_sticky", bus_if.END_OF_PROG, 1'b1);
    check("eop_no_inc", inc_seen, inc_exp);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    eop_exp = 1'b0;
    check("eop_cleared", bus_if.END_OF_PROG, 1'b0);
    do_fetch(8'h20, 2, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/prog_fetch.md
# prog_fetch

Instruction fetch sequencer sitting between the program counter and program memory. On request it captures the counter's 8-bit address, reads one 8-bit word from a synchronous ROM, and delivers it onto the shared 4-bit data bus as two acknowledged nibbles, high nibble first. When the word is consumed it pulses the counter's increment input. It is the consuming end of the counter's memory-address interface.

## Interface
- ADDR_W, 8, address width; must match the counter's memory-address output
- DATA_W, 8, ROM word width; must equal 2*NIB_W
- NIB_W, 4, bus width
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  synchronous, active-high reset
- FETCH  in  1  start request; sampled only in IDLE
- ADDR_IN  in  ADDR_W  current program-counter value
- MEM_ADDR  out  ADDR_W  ROM address
- MEM_EN  out  1  ROM read enable
- MEM_DATA  in  DATA_W  ROM read data, valid the cycle after MEM_EN
- BUS_OUT  out  NIB_W  nibble to bus; high-impedance when not driving
- BUS_VALID  out  1  BUS_OUT holds a valid nibble
- BUS_HI  out  1  1 means the current nibble is the high nibble
- BUS_ACK  in  1  consumer has taken the current nibble
- PC_INC  out  1  one-cycle increment pulse to the counter
- BUSY  out  1  high in every state except IDLE
- END_OF_PROG  out  1  sticky; set after fetching from address all-ones

## Operation
- States are IDLE, READ, LATCH, HI, LO, and INC.
- IDLE: if FETCH=1 and END_OF_PROG=0, capture ADDR_IN into the addr register and go to READ. Otherwise stay.
- READ: MEM_ADDR = addr register, MEM_EN=1 for exactly one cycle, then go to LATCH.
- LATCH: capture MEM_DATA into the word register, then go to HI.
- HI: BUS_OUT = word[DATA_W-1:NIB_W], BUS_VALID=1, BUS_HI=1. Hold until BUS_ACK=1, then go to LO.
- LO: BUS_OUT = word[NIB_W-1:0], BUS_VALID=1, BUS_HI=0. Hold until BUS_ACK=1, then go to INC.
- INC: PC_INC=1 for exactly one cycle. If the addr register is all-ones, set END_OF_PROG. Then go to IDLE.
- FETCH outside IDLE is ignored. Requests are not queued.
- BUS_ACK outside HI/LO is ignored. An ACK that is still held high when entering LO is consumed by LO on that same cycle. The consumer must therefore deassert ACK for at least one cycle between nibbles.
- END_OF_PROG=1 blocks further fetches. It is cleared only by Rst. This mirrors the counter saturating at all-ones.
- The addr register is frozen from the IDLE capture until return to IDLE. A counter change mid-fetch does not affect the word already being fetched.
- Reset values:
  - state IDLE
  - MEM_EN=0, BUS_VALID=0, BUS_HI=0, PC_INC=0, BUSY=0, END_OF_PROG=0
  - BUS_OUT all-Z
  - MEM_ADDR=0
  - addr and word registers = 0
- Rst in any state takes effect on the next rising edge: state returns to IDLE, the bus is released, and no PC_INC is emitted.

## Timing
- FETCH sampled at edge 0 → MEM_EN high in cycle 1 → word latched at edge 2 → high nibble valid from cycle 3.
- With ACK given on the first valid cycle of each nibble, the sequence is:
  - PC_INC high in cycle 5
  - BUSY low in cycle 6
  - minimum fetch period: 6 cycles
- Each nibble phase lasts 1 + (cycles waiting for ACK).
- The counter updates on the falling edge. ADDR_IN is therefore stable a half cycle before any rising edge, and the PC_INC pulse is seen by the counter mid-cycle 5.
- All outputs are registered-state decodes. There is no combinational path from BUS_ACK to BUS_OUT.

## Structure
- The shared package holds:
  - state encoding constants: IDLE=0, READ=1, LATCH=2, HI=3, LO=4, INC=5, as a 3-bit field
  - ADDR_W, DATA_W, NIB_W defaults
  - the all-ones address constant
- No sub-module is needed: one FSM plus the addr and word registers, with a tri-state driver at the top level.
- The bench supplies a 256x8 synchronous ROM model.

## Test plan
- Single fetch: ROM[0x10]=0xA7, ADDR_IN=0x10, FETCH pulse, ACK immediate → BUS_OUT 0xA (BUS_HI=1) in cycle 3, then 0x7 in cycle 4, PC_INC in cycle 5, BUSY=0 in cycle 6.
- Stalled consumer: ACK delayed 3 cycles per nibble → each nibble held stable with BUS_VALID=1 for 4 cycles; exactly one PC_INC.
- Held ACK: ACK tied high through HI → high nibble lasts 1 cycle and low nibble is consumed immediately. Then, with ACK dropped between nibbles, the low nibble is held until ACK is asserted again.
- Ignored inputs: FETCH pulsed during HI, and ADDR_IN changed 0x10→0x11 mid-fetch → the word from 0x10 is delivered, with no second fetch and no extra PC_INC.
- End of program: ADDR_IN=0xFF, ROM[0xFF]=0x3C → nibbles 0x3 and 0xC, END_OF_PROG=1 after INC, a later FETCH is ignored, and Rst clears END_OF_PROG.
- Reset mid-operation: Rst asserted during LO → next edge gives IDLE, BUS_OUT=Z, BUS_VALID=0, no PC_INC; a subsequent fetch works normally.
